wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: sole driver of the register-file write port (reg_write, rd_wb, wd) consumed by id_stage.
//  Formats load data (LB/LH/LW/LBU/LHU), selects ALU / load / PC+4 result, registers it for one-cycle writeback.
//  Arbitrates the single write port between in-order pipeline results and out-of-order M-unit (div/rem) results,
//  buffered in a small FIFO; bounded starvation via a pipeline-stall request.
// PARAMETERS
//  DIV_DEPTH   2   M-unit result FIFO depth (power of 2, >=2)
//  STARVE_MAX  4   consecutive cycles FIFO may be non-empty without draining before pipe_stall asserts
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   MEM/WB result valid this cycle
//  in_reg_write   in   1   instruction writes rd
//  in_rd          in   5   destination register
//  in_memtoreg    in   1   result is load data
//  in_jump        in   1   JAL/JALR: result is pc_plus4
//  in_funct3      in   3   load width/sign (LB=000 LH=001 LW=010 LBU=100 LHU=101)
//  in_alu_result  in   32  ALU result / load address (bits [1:0] = byte offset)
//  in_mem_rdata   in   32  word-aligned memory read data
//  in_pc_plus4    in   32  link value
//  div_valid      in   1   M-unit result offered
//  div_rd         in   5   M-unit destination register
//  div_result     in   32  M-unit result
//  div_ready      out  1   FIFO can accept (count < DIV_DEPTH); transfer = div_valid & div_ready
//  pipe_stall     out  1   upstream must hold in_valid=0 this cycle; FIFO head drains
//  reg_write      out  1   register-file write enable (registered)
//  rd_wb          out  5   write address (registered)
//  wd             out  32  write data (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): reg_write=0, rd_wb=0, wd=0, FIFO empty, starve_cnt=0, pipe_stall=0, div_ready=1.
//  Result select (comb): in_jump -> in_pc_plus4; else in_memtoreg -> load_fmt; else in_alu_result.
//  load_fmt: off=in_alu_result[1:0]; byte=rdata[8*off+:8]; half=rdata[16*off[1]+:16] (off[0] ignored);
//   LB/LH sign-extend, LBU/LHU zero-extend, LW and any other funct3 -> full word.
//  pipe_wr = in_valid & in_reg_write & (in_rd!=0) & ~pipe_stall.
//  Per cycle, one winner updates output regs at next edge (latency 1 cycle):
//   pipe_stall=1  -> pop FIFO head: reg_write=1, rd_wb/wd=head; in_* ignored.
//   else pipe_wr  -> reg_write=1, rd_wb=in_rd, wd=selected result; FIFO holds.
//   else FIFO non-empty -> pop head as above.
//   else reg_write=0; rd_wb/wd hold previous values.
//  FIFO: push on div_valid & div_ready, entry {div_rd,div_result}; div_rd==0 accepted and discarded.
//   Pushed entry not poppable in same cycle (empty+push -> earliest pop next cycle).
//   Push and pop same cycle: count unchanged. Read/write pointers wrap modulo DIV_DEPTH.
//   div_ready from registered count only (no same-cycle pop pass-through).
//  starve_cnt: +1 (saturating) each cycle FIFO non-empty and no pop; cleared on any pop or when empty.
//   pipe_stall = (starve_cnt == STARVE_MAX) & FIFO non-empty (comb); forces pop that cycle.
//  Pipeline write with rd==0 or in_reg_write=0: no write; FIFO may drain that cycle.
//  Same rd from pipeline and FIFO: issue order as arbitrated; no reordering/merge (scheduler guarantees WAW).
//  Reset mid-operation: FIFO contents lost, any pending write dropped; outputs as reset values.
// TESTING
//  1 ALU: in_valid,rd=7,alu=0x1234 -> next cycle reg_write=1,rd_wb=7,wd=0x1234; following cycle reg_write=0.
//  2 Loads, rdata=0x8081F2F3: LB off=2 -> 0xFFFFFF81; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF8081;
//    LHU off=0 -> 0x0000F2F3; LW -> 0x8081F2F3.
//  3 JAL rd=1, pc_plus4=0x104, alu=0xDEAD -> wd=0x104; same with rd=0 -> reg_write stays 0.
//  4 div push rd=5,0x2A with pipeline idle -> write x5=0x2A two edges after push; div_rd=0 push -> no write.
//  5 FIFO full (2 pushes during continuous pipe writes) -> div_ready=0; 3rd offer held until pop.
//  6 Continuous pipe writes, FIFO non-empty -> pipe_stall=1 in the 5th cycle (STARVE_MAX=4), head written,
//    starve_cnt clears; assert rst_n=0 mid-stream -> all outputs 0, div_ready=1 immediately.

Source files
------------

// File: rtl/wb_stage_if.sv
// Writeback stage bus: pipeline result and M-unit offer in, write port and flow control out.
interface wb_stage_if;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic        in_memtoreg;
    logic        in_jump;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_result;
    logic        div_ready;
    logic        pipe_stall;
    logic        reg_write;
    logic [4:0]  rd_wb;
    logic [31:0] wd;

    modport master (
        output in_valid, in_reg_write, in_rd, in_memtoreg, in_jump, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4, div_valid, div_rd, div_result,
        input  div_ready, pipe_stall, reg_write, rd_wb, wd
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_memtoreg, in_jump, in_funct3,
               in_alu_result, in_mem_rdata, in_pc_plus4, div_valid, div_rd, div_result,
        output div_ready, pipe_stall, reg_write, rd_wb, wd
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: formats the pipeline result and arbitrates the single register-file
// write port between in-order results and buffered out-of-order M-unit results.
module wb_stage #(
    parameter int DIV_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);
    localparam int PTR_W = (DIV_DEPTH > 1) ? $clog2(DIV_DEPTH) : 1;
    localparam int CNT_W = $clog2(DIV_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DIV_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    logic [4:0]       fifo_rd_q   [DIV_DEPTH];
    logic [31:0]      fifo_data_q [DIV_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_wb_q, rd_wb_d;
    logic [31:0]      wd_q, wd_d;

    logic        fifo_empty;
    logic        div_ready;
    logic        pipe_stall;
    logic        pipe_wr;
    logic        push;
    logic        pop;
    logic [1:0]  load_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_fmt;
    logic [31:0] result_sel;

    always_comb begin
        load_off  = bus.in_alu_result[1:0];
        load_byte = bus.in_mem_rdata[{load_off, 3'b000} +: 8];
        load_half = load_off[1] ? bus.in_mem_rdata[31:16] : bus.in_mem_rdata[15:0];
        case (bus.in_funct3)
            3'b000:  load_fmt = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b100:  load_fmt = {24'd0, load_byte};
            3'b101:  load_fmt = {16'd0, load_half};
            default: load_fmt = bus.in_mem_rdata;
        endcase
        if (bus.in_jump)
            result_sel = bus.in_pc_plus4;
        else if (bus.in_memtoreg)
            result_sel = load_fmt;
        else
            result_sel = bus.in_alu_result;
    end

    // Flow control looks only at registered state, so an entry pushed this cycle cannot pop until next.
    always_comb begin
        fifo_empty = (count_q == '0);
        div_ready  = (count_q < DEPTH_C);
        pipe_stall = (starve_q == STARVE_C) && !fifo_empty;
        pipe_wr    = bus.in_valid && bus.in_reg_write && (bus.in_rd != 5'd0) && !pipe_stall;
        push       = bus.div_valid && div_ready && (bus.div_rd != 5'd0);
        pop        = pipe_stall || (!pipe_wr && !fifo_empty);
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q != STARVE_C)
            starve_d = starve_q + STV_W'(1);
        else
            starve_d = starve_q;
    end

    always_comb begin
        reg_write_d = 1'b0;
        rd_wb_d     = rd_wb_q;
        wd_d        = wd_q;
        if (pop) begin
            reg_write_d = 1'b1;
            rd_wb_d     = fifo_rd_q[rd_ptr_q];
            wd_d        = fifo_data_q[rd_ptr_q];
        end else if (pipe_wr) begin
            reg_write_d = 1'b1;
            rd_wb_d     = bus.in_rd;
            wd_d        = result_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            rd_wb_q     <= 5'd0;
            wd_q        <= 32'd0;
            for (int i = 0; i < DIV_DEPTH; i++) begin
                fifo_rd_q[i]   <= 5'd0;
                fifo_data_q[i] <= 32'd0;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            rd_wb_q     <= rd_wb_d;
            wd_q        <= wd_d;
            if (push) begin
                fifo_rd_q[wr_ptr_q]   <= bus.div_rd;
                fifo_data_q[wr_ptr_q] <= bus.div_result;
            end
        end
    end

    assign bus.div_ready  = div_ready;
    assign bus.pipe_stall = pipe_stall;
    assign bus.reg_write  = reg_write_q;
    assign bus.rd_wb      = rd_wb_q;
    assign bus.wd         = wd_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: result select, load formatting, M-unit FIFO arbitration,
// starvation stall and asynchronous reset.
module tb_wb_stage;
   logic clk = 1'b0;
   logic rst_n;
   int   assertCount = 0;
   int   failCount   = 0;

   always #5 clk = ~clk;

   wb_stage_if bus();

   wb_stage #(.DIV_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Load vectors against rdata 0x8081F2F3 (funct3, byte offset, expected write data)
   logic [2:0]  ldF3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b100, 3'b000};
   logic [1:0]  ldOff [9] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0};
   logic [31:0] ldExp [9] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3, 32'h8081F2F3,
                              32'hFFFF8081, 32'h8081F2F3, 32'h000000F2, 32'hFFFFFFF3};

   // Single comparison point; every check counts here and reports its own mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic regWrite, input logic [4:0] rd,
                                input logic memToReg, input logic jump, input logic [2:0] funct3,
                                input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pcPlus4);
      bus.in_valid      = valid;
      bus.in_reg_write  = regWrite;
      bus.in_rd         = rd;
      bus.in_memtoreg   = memToReg;
      bus.in_jump       = jump;
      bus.in_funct3     = funct3;
      bus.in_alu_result = alu;
      bus.in_mem_rdata  = rdata;
      bus.in_pc_plus4   = pcPlus4;
   endtask

   task automatic applyDiv(input logic valid, input logic [4:0] rd, input logic [31:0] result);
      bus.div_valid  = valid;
      bus.div_rd     = rd;
      bus.div_result = result;
   endtask

   task automatic pipeIdle();
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic pipeAlu(input logic [4:0] rd, input logic [31:0] alu);
      applyStimulus(1'b1, 1'b1, rd, 1'b0, 1'b0, 3'b000, alu, 32'd0, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      pipeIdle();
      applyDiv(1'b0, 5'd0, 32'd0);
      #2;
      checkOutput("rst_reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("rst_rd_wb", 32'(bus.rd_wb), 32'd0);
      checkOutput("rst_wd", bus.wd, 32'd0);
      checkOutput("rst_div_ready", 32'(bus.div_ready), 32'd1);
      checkOutput("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // ALU result written one cycle later, then write enable drops
      pipeAlu(5'd7, 32'h1234);
      tick();
      pipeIdle();
      checkOutput("alu_reg_write", 32'(bus.reg_write), 32'd1);
      checkOutput("alu_rd_wb", 32'(bus.rd_wb), 32'd7);
      checkOutput("alu_wd", bus.wd, 32'h1234);
      tick();
      checkOutput("alu_idle_reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("alu_idle_wd_hold", bus.wd, 32'h1234);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b1, 5'(16 + i), 1'b1, 1'b0, ldF3[i], {30'h400, ldOff[i]},
                       32'h8081F2F3, 32'h0);
         tick();
         checkOutput($sformatf("load%0d_wd", i), bus.wd, ldExp[i]);
      end
      pipeIdle();

      // Link value beats ALU result; rd 0 and no-write instructions never reach the port
      applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 3'b000, 32'hDEAD, 32'h0, 32'h104);
      tick();
      checkOutput("jal_rd_wb", 32'(bus.rd_wb), 32'd1);
      checkOutput("jal_wd", bus.wd, 32'h104);
      applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 3'b000, 32'hDEAD, 32'h0, 32'h204);
      tick();
      checkOutput("jal_x0_reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("jal_x0_wd_hold", bus.wd, 32'h104);
      applyStimulus(1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 3'b000, 32'hBEEF, 32'h0, 32'h0);
      tick();
      checkOutput("nowrite_reg_write", 32'(bus.reg_write), 32'd0);
      pipeIdle();

      // M-unit result with idle pipeline: stored at first edge, written at second
      applyDiv(1'b1, 5'd5, 32'h2A);
      tick();
      applyDiv(1'b0, 5'd0, 32'd0);
      checkOutput("div_first_edge_reg_write", 32'(bus.reg_write), 32'd0);
      tick();
      checkOutput("div_reg_write", 32'(bus.reg_write), 32'd1);
      checkOutput("div_rd_wb", 32'(bus.rd_wb), 32'd5);
      checkOutput("div_wd", bus.wd, 32'h2A);
      tick();
      checkOutput("div_drained_reg_write", 32'(bus.reg_write), 32'd0);
      applyDiv(1'b1, 5'd0, 32'h55);
      tick();
      applyDiv(1'b0, 5'd0, 32'd0);
      tick();
      checkOutput("div_x0_reg_write", 32'(bus.reg_write), 32'd0);
      tick();
      checkOutput("div_x0_reg_write_late", 32'(bus.reg_write), 32'd0);
      checkOutput("div_x0_wd_hold", bus.wd, 32'h2A);

      // Fill FIFO under continuous pipe writes, then starvation forces the head out
      pipeAlu(5'd10, 32'h100);
      applyDiv(1'b1, 5'd6, 32'h66);
      tick();
      checkOutput("fill_pipe_wd0", bus.wd, 32'h100);
      pipeAlu(5'd11, 32'h101);
      applyDiv(1'b1, 5'd7, 32'h77);
      checkOutput("fill_div_ready1", 32'(bus.div_ready), 32'd1);
      tick();
      pipeAlu(5'd12, 32'h102);
      applyDiv(1'b1, 5'd8, 32'h88);
      checkOutput("full_div_ready", 32'(bus.div_ready), 32'd0);
      checkOutput("starve1_pipe_stall", 32'(bus.pipe_stall), 32'd0);
      tick();
      checkOutput("starve_pipe_wd", bus.wd, 32'h102);
      pipeAlu(5'd13, 32'h103);
      tick();
      pipeAlu(5'd14, 32'h104);
      checkOutput("starve4_pipe_stall", 32'(bus.pipe_stall), 32'd0);
      tick();
      checkOutput("stall_pipe_stall", 32'(bus.pipe_stall), 32'd1);
      checkOutput("stall_div_ready", 32'(bus.div_ready), 32'd0);
      pipeIdle();
      tick();
      checkOutput("stall_pop_rd_wb", 32'(bus.rd_wb), 32'd6);
      checkOutput("stall_pop_wd", bus.wd, 32'h66);
      checkOutput("stall_cleared", 32'(bus.pipe_stall), 32'd0);
      checkOutput("held_offer_ready", 32'(bus.div_ready), 32'd1);
      pipeAlu(5'd15, 32'h105);
      tick();
      applyDiv(1'b0, 5'd0, 32'd0);
      checkOutput("after_stall_pipe_wd", bus.wd, 32'h105);
      pipeIdle();
      tick();
      checkOutput("drain1_wd", bus.wd, 32'h77);
      tick();
      checkOutput("drain2_rd_wb", 32'(bus.rd_wb), 32'd8);
      checkOutput("drain2_wd", bus.wd, 32'h88);
      tick();
      checkOutput("drained_reg_write", 32'(bus.reg_write), 32'd0);

      // Reset with a full FIFO and a write in flight
      pipeAlu(5'd20, 32'hA0);
      applyDiv(1'b1, 5'd21, 32'hC1);
      tick();
      applyDiv(1'b1, 5'd22, 32'hC2);
      pipeAlu(5'd23, 32'hA1);
      tick();
      applyDiv(1'b0, 5'd0, 32'd0);
      checkOutput("prerst_div_ready", 32'(bus.div_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_reg_write", 32'(bus.reg_write), 32'd0);
      checkOutput("midrst_rd_wb", 32'(bus.rd_wb), 32'd0);
      checkOutput("midrst_wd", bus.wd, 32'd0);
      checkOutput("midrst_div_ready", 32'(bus.div_ready), 32'd1);
      pipeIdle();
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("postrst_reg_write", 32'(bus.reg_write), 32'd0);
      tick();
      checkOutput("postrst_fifo_lost", 32'(bus.reg_write), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
